cache_fill_fsm: RTL and testbench

Cache-miss fill controller that sits directly upstream of the 4-bit counter registers and the cache data/tag arrays. On a miss it latches the block base address and issues eight sequential word reads to main memory. It counts returning words and drives the data-array write strobes, then the tag-array write on the last word. The next-count values it computes are what the 4-bit state/counter registers store.

---
 rtl/cache_fill_fsm_pkg.sv | 18 +
 rtl/cache_fill_fsm_if.sv | 39 +++
 rtl/fill_counter_4.sv | 21 ++
 rtl/cache_fill_fsm.sv | 104 ++++++++++
 tb/tb_cache_fill_fsm.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// rtl/cache_fill_fsm_pkg.sv - shared state encoding and block geometry for the cache fill controller
package cache_fill_fsm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int WORD_SHIFT      = 1;
    localparam int WORDS_PER_BLOCK = 8;

    function automatic int block_offset_mask(input int words);
        return (words << WORD_SHIFT) - 1;
    endfunction

    localparam int BLOCK_OFFSET_MASK = block_offset_mask(WORDS_PER_BLOCK);

endpackage

// File: rtl/cache_fill_fsm_if.sv
// rtl/cache_fill_fsm_if.sv - miss/memory/array handshake bundle between pipeline and fill controller
interface cache_fill_fsm_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  miss_detected;
    logic [ADDR_WIDTH-1:0] miss_address;
    logic                  memory_data_valid;
    logic                  fsm_busy;
    logic                  memory_read;
    logic [ADDR_WIDTH-1:0] memory_address;
    logic                  write_data_array;
    logic [ADDR_WIDTH-1:0] fill_address;
    logic                  write_tag_array;

    modport master (
        output miss_detected,
        output miss_address,
        output memory_data_valid,
        input  fsm_busy,
        input  memory_read,
        input  memory_address,
        input  write_data_array,
        input  fill_address,
        input  write_tag_array
    );

    modport slave (
        input  miss_detected,
        input  miss_address,
        input  memory_data_valid,
        output fsm_busy,
        output memory_read,
        output memory_address,
        output write_data_array,
        output fill_address,
        output write_tag_array
    );

endinterface

// File: rtl/fill_counter_4.sv
// rtl/fill_counter_4.sv - incrementing word counter with synchronous clear and enable
module fill_counter_4 #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] count
);

    // Clear wins over enable so a new fill always starts from word zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache-miss block fill controller: issues word reads, strobes data and tag writes
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = cache_fill_fsm_pkg::WORDS_PER_BLOCK,
    parameter int CNT_WIDTH       = 4
) (
    input logic             clk,
    input logic             rst,
    cache_fill_fsm_if.slave bus
);

    localparam int MASK_INT = (WORDS_PER_BLOCK == cache_fill_fsm_pkg::WORDS_PER_BLOCK)
                              ? BLOCK_OFFSET_MASK : block_offset_mask(WORDS_PER_BLOCK);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(MASK_INT);
    localparam logic [CNT_WIDTH-1:0]  FULL_CNT    = CNT_WIDTH'(WORDS_PER_BLOCK);
    localparam logic [CNT_WIDTH-1:0]  LAST_WORD   = CNT_WIDTH'(WORDS_PER_BLOCK - 1);

    fill_state_t           state_q;
    fill_state_t           state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]  issue_cnt;
    logic [CNT_WIDTH-1:0]  recv_cnt;
    logic                  cnt_clear;
    logic                  issue_en;
    logic                  recv_en;

    function automatic logic [ADDR_WIDTH-1:0] word_offset(input logic [CNT_WIDTH-1:0] cnt);
        return ADDR_WIDTH'(cnt) << WORD_SHIFT;
    endfunction

    fill_counter_4 #(.CNT_WIDTH(CNT_WIDTH)) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (issue_en),
        .count (issue_cnt)
    );

    fill_counter_4 #(.CNT_WIDTH(CNT_WIDTH)) u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (recv_en),
        .count (recv_cnt)
    );

    // Base is only captured from IDLE, so misses seen mid-fill never disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.miss_detected) begin
                base_q <= bus.miss_address & ~OFFSET_MASK;
            end
        end
    end

    always_comb begin
        state_d              = state_q;
        cnt_clear            = 1'b0;
        issue_en             = 1'b0;
        recv_en              = 1'b0;
        bus.fsm_busy         = 1'b0;
        bus.memory_read      = 1'b0;
        bus.memory_address   = base_q;
        bus.write_data_array = 1'b0;
        bus.fill_address     = base_q;
        bus.write_tag_array  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.miss_detected) begin
                    cnt_clear = 1'b1;
                    state_d   = FILL;
                end
            end
            FILL: begin
                bus.fsm_busy = 1'b1;
                // Requests and returns are tracked independently: memory may answer
                // while requests are still going out, with any spacing.
                if (issue_cnt < FULL_CNT) begin
                    bus.memory_read    = 1'b1;
                    bus.memory_address = base_q + word_offset(issue_cnt);
                    issue_en           = 1'b1;
                end
                if (bus.memory_data_valid) begin
                    bus.write_data_array = 1'b1;
                    bus.fill_address     = base_q + word_offset(recv_cnt);
                    recv_en              = 1'b1;
                    if (recv_cnt == LAST_WORD) begin
                        bus.write_tag_array = 1'b1;
                        state_d             = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - directed scoreboard bench for the cache fill controller
module tb_cache_fill_fsm;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_fill_fsm_if #(.ADDR_WIDTH(16)) bus ();

    cache_fill_fsm #(
        .ADDR_WIDTH      (16),
        .WORDS_PER_BLOCK (8),
        .CNT_WIDTH       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks    = 0;
    int          errors    = 0;
    int          tag_count = 0;
    bit          sb_on     = 1'b0;
    logic [15:0] req_q[$];
    logic [15:0] wr_q[$];
    logic [15:0] tag_q[$];

    int lat4[8]  = '{4, 0, 0, 0, 0, 0, 0, 0};
    int lat0[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    int lat2[8]  = '{2, 0, 0, 0, 0, 0, 0, 0};
    int irr[8];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string t);
        chk({t, "_busy"}, 16'(bus.fsm_busy), 16'h0);
        chk({t, "_read"}, 16'(bus.memory_read), 16'h0);
        chk({t, "_maddr"}, bus.memory_address, 16'h0);
        chk({t, "_wda"}, 16'(bus.write_data_array), 16'h0);
        chk({t, "_faddr"}, bus.fill_address, 16'h0);
        chk({t, "_tag"}, 16'(bus.write_tag_array), 16'h0);
    endtask

    // Scoreboard: every request/write/tag strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (bus.write_tag_array) tag_count++;
        if (sb_on && !rst) begin
            if (bus.memory_read) begin
                chk("req_pending", 16'(req_q.size() != 0), 16'h1);
                if (req_q.size() != 0) chk("req_addr", bus.memory_address, req_q.pop_front());
            end
            if (bus.write_data_array) begin
                chk("wr_pending", 16'(wr_q.size() != 0), 16'h1);
                if (wr_q.size() != 0) chk("fill_addr", bus.fill_address, wr_q.pop_front());
            end
            if (bus.write_tag_array) begin
                chk("tag_with_data", 16'(bus.write_data_array), 16'h1);
                chk("tag_pending", 16'(tag_q.size() != 0), 16'h1);
                if (tag_q.size() != 0) chk("tag_addr", bus.fill_address & 16'hFFF0, tag_q.pop_front());
            end
        end
    end

    // Called just after a rising edge in an IDLE cycle; gaps[0] is the latency to the first word.
    task automatic run_fill(input logic [15:0] addr, input int gaps[8], input bit hold_miss, input bit chain);
        int          vcyc[8];
        int          last;
        logic [15:0] base;
        bit          v;
        base = {addr[15:4], 4'h0};
        for (int i = 0; i < 8; i++) begin
            req_q.push_back({base[15:4], 3'(i), 1'b0});
            wr_q.push_back({base[15:4], 3'(i), 1'b0});
        end
        tag_q.push_back(base);
        vcyc[0] = 1 + gaps[0];
        for (int i = 1; i < 8; i++) vcyc[i] = vcyc[i-1] + 1 + gaps[i];
        last = vcyc[7];

        bus.miss_detected     = 1'b1;
        bus.miss_address      = addr;
        bus.memory_data_valid = 1'b0;
        @(negedge clk);
        chk("miss_cycle_busy", 16'(bus.fsm_busy), 16'h0);
        @(posedge clk); #1;
        for (int k = 1; k <= last; k++) begin
            v = 1'b0;
            for (int j = 0; j < 8; j++) if (vcyc[j] == k) v = 1'b1;
            bus.miss_detected     = hold_miss;
            bus.miss_address      = 16'h5554;
            bus.memory_data_valid = v;
            @(negedge clk);
            chk("fill_busy", 16'(bus.fsm_busy), 16'h1);
            chk("fill_read", 16'(bus.memory_read), 16'(k <= 8));
            chk("fill_wda", 16'(bus.write_data_array), 16'(v));
            chk("fill_tag", 16'(bus.write_tag_array), 16'(k == last));
            @(posedge clk); #1;
        end
        bus.miss_detected     = 1'b0;
        bus.memory_data_valid = 1'b0;
        if (!chain) begin
            @(negedge clk);
            chk("done_busy", 16'(bus.fsm_busy), 16'h0);
            chk("done_read", 16'(bus.memory_read), 16'h0);
            chk("req_q_drained", 16'(req_q.size()), 16'h0);
            chk("wr_q_drained", 16'(wr_q.size()), 16'h0);
            chk("tag_q_drained", 16'(tag_q.size()), 16'h0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int tags_before;
        rst                   = 1'b1;
        bus.miss_detected     = 1'b0;
        bus.miss_address      = 16'h0;
        bus.memory_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset_idle");
        sb_on = 1'b1;
        @(posedge clk); #1;

        run_fill(16'h1234, lat4, 1'b0, 1'b0);
        run_fill(16'hFFFE, lat0, 1'b0, 1'b0);

        foreach (irr[i]) irr[i] = int'($urandom_range(0, 3));
        run_fill(16'h3456, irr, 1'b1, 1'b0);

        // Abort a fill after its third returned word.
        sb_on       = 1'b0;
        tags_before = tag_count;
        bus.miss_detected = 1'b1;
        bus.miss_address  = 16'h2000;
        @(posedge clk); #1;
        bus.miss_detected = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus.memory_data_valid = (k >= 2);
            @(posedge clk); #1;
        end
        bus.memory_data_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("mid_fill_reset");
        chk("mid_fill_no_tag", 16'(tag_count - tags_before), 16'h0);
        req_q.delete();
        wr_q.delete();
        tag_q.delete();
        sb_on = 1'b1;
        @(posedge clk); #1;
        run_fill(16'h0040, lat2, 1'b0, 1'b0);

        // Returning words while idle must not strobe anything.
        tags_before = tag_count;
        for (int k = 0; k < 3; k++) begin
            bus.memory_data_valid = 1'b1;
            @(negedge clk);
            chk("idle_valid_wda", 16'(bus.write_data_array), 16'h0);
            chk("idle_valid_busy", 16'(bus.fsm_busy), 16'h0);
            @(posedge clk); #1;
        end
        bus.memory_data_valid = 1'b0;
        chk("idle_valid_no_tag", 16'(tag_count - tags_before), 16'h0);

        // Miss in the cycle right after write_tag_array starts the next fill.
        run_fill(16'h7777, lat0, 1'b0, 1'b1);
        run_fill(16'h8888, lat2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
